// File: rtl/iot_monitor_multi.sv
// Multi-channel active-device monitor: per-channel up/down counters (wrap or saturate),
// direct load, threshold alarms, sticky overflow/underflow flags and a registered total.
module iot_monitor_multi #(
  parameter int CHANNELS     = 4,
  parameter int WIDTH        = 8,
  parameter int SATURATE     = 0,
  parameter int ALARM_THRESH = 200,
  localparam int LCW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int TW  = WIDTH + $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear,
  input  logic [CHANNELS-1:0]       change,
  input  logic [CHANNELS-1:0]       on_off,
  input  logic                      load,
  input  logic [LCW-1:0]            load_ch,
  input  logic [WIDTH-1:0]          load_val,
  input  logic                      flag_clr,
  output logic [CHANNELS*WIDTH-1:0] count_flat,
  output logic [CHANNELS-1:0]       alarm,
  output logic [CHANNELS-1:0]       ovf,
  output logic [CHANNELS-1:0]       unf,
  output logic [TW-1:0]             total
);

  localparam logic [WIDTH-1:0] MAX_V  = '1;
  localparam logic [WIDTH-1:0] THRESH = WIDTH'(ALARM_THRESH);

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [WIDTH-1:0] cnt_q, cnt_d;
      logic             ovf_q, ovf_d, unf_q, unf_d, alarm_q;
      logic             ovf_evt, unf_evt, load_sel;

      // An out-of-range load_ch never matches any channel, so such loads fall away.
      assign load_sel = load && (load_ch == LCW'(gi));

      always_comb begin
        cnt_d   = cnt_q;
        ovf_evt = 1'b0;
        unf_evt = 1'b0;
        if (clear) begin
          cnt_d = '0;
        end else if (load_sel) begin
          cnt_d = load_val;
        end else if (change[gi]) begin
          if (on_off[gi]) begin
            if (cnt_q == MAX_V) begin
              ovf_evt = 1'b1;
              cnt_d   = (SATURATE != 0) ? MAX_V : '0;
            end else begin
              cnt_d = cnt_q + WIDTH'(1);
            end
          end else begin
            if (cnt_q == '0) begin
              unf_evt = 1'b1;
              cnt_d   = (SATURATE != 0) ? '0 : MAX_V;
            end else begin
              cnt_d = cnt_q - WIDTH'(1);
            end
          end
        end
        // A fresh event beats flag_clr; clear beats everything.
        ovf_d = !clear && (ovf_evt || (ovf_q && !flag_clr));
        unf_d = !clear && (unf_evt || (unf_q && !flag_clr));
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_q   <= '0;
          ovf_q   <= 1'b0;
          unf_q   <= 1'b0;
          alarm_q <= 1'b0;
        end else begin
          cnt_q   <= cnt_d;
          ovf_q   <= ovf_d;
          unf_q   <= unf_d;
          alarm_q <= (cnt_d >= THRESH);
        end
      end

      assign count_flat[gi*WIDTH +: WIDTH] = cnt_q;
      assign alarm[gi] = alarm_q;
      assign ovf[gi]   = ovf_q;
      assign unf[gi]   = unf_q;
    end
  endgenerate

  logic [TW-1:0] sum_d;
  logic [TW-1:0] total_q;

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      sum_d = sum_d + TW'(count_flat[i*WIDTH +: WIDTH]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) total_q <= '0;
    else        total_q <= sum_d;
  end

  assign total = total_q;

endmodule

// File: tb/tb_iot_monitor_multi.sv
// Scoreboard bench: a wrap-mode and a saturate-mode instance share stimulus; a
// behavioural model pushes expected outputs, a monitor pops and compares each cycle.
module tb_iot_monitor_multi;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       clear = 1'b0, load = 1'b0, flag_clr = 1'b0;
  logic [3:0] change = '0, on_off = '0;
  logic [1:0] load_ch = '0;
  logic [7:0] load_val = '0;

  logic [31:0] cf_w, cf_s;
  logic [3:0]  al_w, ov_w, un_w, al_s, ov_s, un_s;
  logic [9:0]  tot_w, tot_s;

  int total = 0;
  int bad   = 0;
  int ncyc  = 0;

  always #5 clk = ~clk;

  iot_monitor_multi #(.CHANNELS(4), .WIDTH(8), .SATURATE(0), .ALARM_THRESH(200)) u_wrap (
    .clk(clk), .rst_n(rst_n), .clear(clear), .change(change), .on_off(on_off),
    .load(load), .load_ch(load_ch), .load_val(load_val), .flag_clr(flag_clr),
    .count_flat(cf_w), .alarm(al_w), .ovf(ov_w), .unf(un_w), .total(tot_w));

  iot_monitor_multi #(.CHANNELS(4), .WIDTH(8), .SATURATE(1), .ALARM_THRESH(200)) u_sat (
    .clk(clk), .rst_n(rst_n), .clear(clear), .change(change), .on_off(on_off),
    .load(load), .load_ch(load_ch), .load_val(load_val), .flag_clr(flag_clr),
    .count_flat(cf_s), .alarm(al_s), .ovf(ov_s), .unf(un_s), .total(tot_s));

  typedef struct packed {
    logic [31:0] cf;
    logic [3:0]  al;
    logic [3:0]  ov;
    logic [3:0]  un;
    logic [9:0]  tot;
  } exp_t;

  exp_t q_w[$];
  exp_t q_s[$];
  exp_t ew, es;

  // Reference state: plain integers, index 0 = wrap instance, 1 = saturate instance.
  int m_cnt[2][4];
  bit m_ovf[2][4];
  bit m_unf[2][4];
  int m_tot[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic void model_step(input int d);
    int s;
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        m_cnt[d][i] = 0; m_ovf[d][i] = 0; m_unf[d][i] = 0;
      end
      m_tot[d] = 0;
      return;
    end
    s = 0;
    for (int i = 0; i < 4; i++) s += m_cnt[d][i];
    m_tot[d] = s;
    for (int i = 0; i < 4; i++) begin
      int  c;
      bit  eo, eu;
      c = m_cnt[d][i]; eo = 0; eu = 0;
      if (clear) c = 0;
      else if (load && int'(load_ch) == i) c = int'(load_val);
      else if (change[i] && on_off[i]) begin
        c = c + 1;
        if (c > 255) begin eo = 1; c = (d == 1) ? 255 : c % 256; end
      end else if (change[i]) begin
        c = c - 1;
        if (c < 0) begin eu = 1; c = (d == 1) ? 0 : c + 256; end
      end
      m_cnt[d][i] = c;
      m_ovf[d][i] = clear ? 1'b0 : (eo ? 1'b1 : (flag_clr ? 1'b0 : m_ovf[d][i]));
      m_unf[d][i] = clear ? 1'b0 : (eu ? 1'b1 : (flag_clr ? 1'b0 : m_unf[d][i]));
    end
  endfunction

  function automatic exp_t model_out(input int d);
    exp_t e;
    e = '0;
    for (int i = 0; i < 4; i++) begin
      e.cf[i*8 +: 8] = 8'(m_cnt[d][i]);
      e.al[i] = (m_cnt[d][i] >= 200);
      e.ov[i] = m_ovf[d][i];
      e.un[i] = m_unf[d][i];
    end
    e.tot = 10'(m_tot[d]);
    return e;
  endfunction

  task automatic push_exp();
    model_step(0);
    model_step(1);
    q_w.push_back(model_out(0));
    q_s.push_back(model_out(1));
  endtask

  task automatic cyc(input logic [3:0] ch, input logic [3:0] oo, input logic cl,
                     input logic ld, input logic [1:0] lc, input logic [7:0] lv,
                     input logic fc);
    @(negedge clk);
    change = ch; on_off = oo; clear = cl; load = ld;
    load_ch = lc; load_val = lv; flag_clr = fc;
    push_exp();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(4'h0, 4'h0, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cf_w"},  cf_w,  32'h0);
    chk({tag, "_cf_s"},  cf_s,  32'h0);
    chk({tag, "_flags"}, {16'h0, al_w, ov_w, un_w, al_s}, 32'h0);
    chk({tag, "_flg_s"}, {24'h0, ov_s, un_s}, 32'h0);
    chk({tag, "_tot"},   {12'h0, tot_w, tot_s}, 32'h0);
  endtask

  // Asynchronous reset asserted between edges; outputs must drop before any edge.
  task automatic async_reset(input int hold);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("rst_async");
    change = '0; clear = 0; load = 0; flag_clr = 0;
    push_exp();
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      push_exp();
    end
    @(negedge clk);
    rst_n = 1'b1;
    push_exp();
  endtask

  always begin
    @(posedge clk);
    #1;
    if (q_w.size() > 0 && q_s.size() > 0) begin
      ew = q_w.pop_front();
      es = q_s.pop_front();
      ncyc++;
      $display("txn %0d rst_n=%0b wrap cf=%h tot=%0d | sat cf=%h tot=%0d",
               ncyc, rst_n, cf_w, tot_w, cf_s, tot_s);
      chk("wrap_count", cf_w, ew.cf);
      chk("wrap_alarm", {28'h0, al_w}, {28'h0, ew.al});
      chk("wrap_ovf",   {28'h0, ov_w}, {28'h0, ew.ov});
      chk("wrap_unf",   {28'h0, un_w}, {28'h0, ew.un});
      chk("wrap_total", {22'h0, tot_w}, {22'h0, ew.tot});
      chk("sat_count",  cf_s, es.cf);
      chk("sat_alarm",  {28'h0, al_s}, {28'h0, es.al});
      chk("sat_ovf",    {28'h0, ov_s}, {28'h0, es.ov});
      chk("sat_unf",    {28'h0, un_s}, {28'h0, es.un});
      chk("sat_total",  {22'h0, tot_s}, {22'h0, es.tot});
    end
  end

  initial begin
    logic [7:0] edge_vals [8];
    edge_vals = '{8'd0, 8'd1, 8'd254, 8'd255, 8'd198, 8'd199, 8'd200, 8'd201};
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 4; i++) begin
        m_cnt[d][i] = 0; m_ovf[d][i] = 0; m_unf[d][i] = 0;
      end
      m_tot[d] = 0;
    end

    #1 rst_n = 1'b0;
    #1 chk_all_zero("rst_init");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      push_exp();
    end
    @(negedge clk);
    rst_n = 1'b1;
    push_exp();
    idle(5);

    // Wrap at top and bottom on ch0
    cyc(4'h0, 4'h0, 0, 1, 2'd0, 8'd254, 0);
    for (int k = 0; k < 3; k++) cyc(4'h1, 4'h1, 0, 0, 2'd0, 8'd0, 0);
    cyc(4'h0, 4'h0, 0, 1, 2'd0, 8'd0, 0);
    cyc(4'h1, 4'h0, 0, 0, 2'd0, 8'd0, 0);
    cyc(4'h0, 4'h0, 0, 0, 2'd0, 8'd0, 1);

    // ch1 at the range edges (saturate instance clamps)
    cyc(4'h0, 4'h0, 0, 1, 2'd1, 8'd255, 0);
    cyc(4'h2, 4'h2, 0, 0, 2'd0, 8'd0, 0);
    cyc(4'h0, 4'h0, 0, 1, 2'd1, 8'd0, 0);
    cyc(4'h2, 4'h0, 0, 0, 2'd0, 8'd0, 0);
    cyc(4'h2, 4'h0, 0, 0, 2'd0, 8'd0, 0);

    // Alarm threshold crossing on ch2
    cyc(4'h0, 4'h0, 0, 1, 2'd2, 8'd198, 0);
    for (int k = 0; k < 3; k++) cyc(4'h4, 4'h4, 0, 0, 2'd0, 8'd0, 0);
    cyc(4'h4, 4'h0, 0, 0, 2'd0, 8'd0, 0);
    cyc(4'h4, 4'h0, 0, 0, 2'd0, 8'd0, 0);

    // Totals, including the 4x255 maximum
    for (int i = 0; i < 4; i++) cyc(4'h0, 4'h0, 0, 1, 2'(i), 8'(10 * (i + 1)), 0);
    idle(1);
    cyc(4'hF, 4'hF, 0, 0, 2'd0, 8'd0, 0);
    idle(2);
    for (int i = 0; i < 4; i++) cyc(4'h0, 4'h0, 0, 1, 2'(i), 8'd255, 0);
    idle(2);

    // Reset mid-count
    cyc(4'hF, 4'h5, 0, 0, 2'd0, 8'd0, 0);
    async_reset(2);
    idle(5);

    // Priority cases
    for (int i = 0; i < 4; i++) cyc(4'h0, 4'h0, 0, 1, 2'(i), 8'd77, 0);
    cyc(4'hF, 4'hF, 1, 1, 2'd2, 8'd99, 0);
    cyc(4'h0, 4'h0, 0, 1, 2'd3, 8'd255, 0);
    cyc(4'h8, 4'h8, 0, 0, 2'd0, 8'd0, 0);
    cyc(4'h0, 4'h0, 0, 1, 2'd3, 8'd255, 0);
    cyc(4'h8, 4'h8, 0, 0, 2'd0, 8'd0, 1);
    cyc(4'hF, 4'hF, 0, 1, 2'd2, 8'd123, 0);
    cyc(4'hF, 4'h0, 0, 1, 2'd1, 8'd5, 1);

    // Randomised traffic biased toward range edges
    for (int k = 0; k < 400; k++) begin
      logic [7:0] lv;
      lv = ($urandom_range(0, 1) == 0) ? edge_vals[$urandom_range(0, 7)] : 8'($urandom);
      cyc(4'($urandom), 4'($urandom), ($urandom_range(0, 49) == 0),
          ($urandom_range(0, 5) == 0), 2'($urandom), lv, ($urandom_range(0, 9) == 0));
      if ($urandom_range(0, 149) == 0) async_reset(1);
    end
    idle(2);

    for (int k = 0; k < 10 && (q_w.size() > 0 || q_s.size() > 0); k++) @(posedge clk);
    #2;
    if (q_w.size() > 0 || q_s.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain actual=%0d required=0 pending expectations", q_w.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
